// File: rtl/tug_referee_if.sv
// Signal bundle between the tug-of-war light chain / player inputs and the
// round referee. The referee sits on the slave side; whatever produces the
// button pulses and end-light states (or a testbench) uses the master side.
interface tug_referee_if;
  logic       LeftButton;
  logic       RightButton;
  logic       LeftEndLight;
  logic       RightEndLight;
  logic       roundReset;
  logic [1:0] roundWinner;
  logic       matchOver;
  logic [3:0] LeftScore;
  logic [3:0] RightScore;
  logic [6:0] HEX5;
  logic [6:0] HEX0;

  modport master (
    output LeftButton, RightButton, LeftEndLight, RightEndLight,
    input  roundReset, roundWinner, matchOver, LeftScore, RightScore, HEX5, HEX0
  );

  modport slave (
    input  LeftButton, RightButton, LeftEndLight, RightEndLight,
    output roundReset, roundWinner, matchOver, LeftScore, RightScore, HEX5, HEX0
  );
endinterface

// File: rtl/tug_referee.sv
// Round and match referee for tug-of-war. Declares a round win when a player
// presses while the chain has reached that player's end, keeps both scores,
// holds the result for HOLD_CYCLES cycles, then pulses roundReset to recentre
// the chain. The match ends (terminally) once a score reaches WIN_SCORE.
module tug_referee #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input logic          clock,
  input logic          reset,
  tug_referee_if.slave bus
);

  localparam int             CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]     WIN_VAL   = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] holdCount;
  logic [3:0]    leftScore;
  logic [3:0]    rightScore;
  logic [1:0]    roundWinner;
  logic          matchOver;
  logic          roundReset;

  logic          leftWin;
  logic          rightWin;
  logic [3:0]    leftNext;
  logic [3:0]    rightNext;
  logic [6:0]    hexLeft;
  logic [6:0]    hexRight;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] segDecode(input logic [3:0] value);
    case (value)
      4'd0:    segDecode = 7'b1000000;
      4'd1:    segDecode = 7'b1111001;
      4'd2:    segDecode = 7'b0100100;
      4'd3:    segDecode = 7'b0110000;
      4'd4:    segDecode = 7'b0011001;
      4'd5:    segDecode = 7'b0010010;
      4'd6:    segDecode = 7'b0000010;
      4'd7:    segDecode = 7'b1111000;
      4'd8:    segDecode = 7'b0000000;
      4'd9:    segDecode = 7'b0010000;
      default: segDecode = 7'b1111111;
    endcase
  endfunction

  // Win qualifiers: a press only counts when the chain sits at the presser's
  // end, the other end is dark, and the opponent is not pressing too.
  always_comb begin
    leftWin   = bus.LeftEndLight & bus.LeftButton & ~bus.RightButton & ~bus.RightEndLight;
    rightWin  = bus.RightEndLight & bus.RightButton & ~bus.LeftButton & ~bus.LeftEndLight;
    leftNext  = leftScore + 4'd1;
    rightNext = rightScore + 4'd1;
  end

  // Round/match state machine; every output it drives is a register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= PLAY;
      holdCount   <= '0;
      leftScore   <= 4'd0;
      rightScore  <= 4'd0;
      roundWinner <= 2'b00;
      matchOver   <= 1'b0;
      roundReset  <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          roundReset <= 1'b0;
          if (!roundReset && leftWin) begin
            leftScore   <= leftNext;
            roundWinner <= 2'b10;
            if (leftNext == WIN_VAL) begin
              state     <= OVER;
              matchOver <= 1'b1;
            end else begin
              state     <= HOLD;
              holdCount <= HOLD_LOAD;
            end
          end else if (!roundReset && rightWin) begin
            rightScore  <= rightNext;
            roundWinner <= 2'b01;
            if (rightNext == WIN_VAL) begin
              state     <= OVER;
              matchOver <= 1'b1;
            end else begin
              state     <= HOLD;
              holdCount <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (holdCount == '0) begin
            state       <= PLAY;
            roundWinner <= 2'b00;
            roundReset  <= 1'b1;
          end else begin
            holdCount <= holdCount - 1'b1;
          end
        end
        OVER: begin
          roundReset <= 1'b0;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  // Score digits follow the registered scores directly.
  always_comb begin
    hexLeft  = segDecode(leftScore);
    hexRight = segDecode(rightScore);
  end

  assign bus.roundReset  = roundReset;
  assign bus.roundWinner = roundWinner;
  assign bus.matchOver   = matchOver;
  assign bus.LeftScore   = leftScore;
  assign bus.RightScore  = rightScore;
  assign bus.HEX5        = hexLeft;
  assign bus.HEX0        = hexRight;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee. A timeline model (win edge numbers and
// simple cycle arithmetic) predicts scores, winner code, clear pulse and
// match end; directed steps cover the named scenarios and a random phase
// exercises arbitrary input mixes.
module tb_tug_referee;

  localparam int WIN   = 7;
  localparam int HOLDC = 4;

  logic clock;
  logic reset;

  tug_referee_if bus ();

  tug_referee #(
    .WIN_SCORE  (WIN),
    .HOLD_CYCLES(HOLDC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  int         cyc;
  int         lScore;
  int         rScore;
  bit         over;
  int         lastWin;
  int         acceptFrom;
  logic [1:0] code;

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Digit patterns written straight from the display table.
  function automatic logic [6:0] hexOf(input int v);
    case (v)
      0:       hexOf = 7'b1000000;
      1:       hexOf = 7'b1111001;
      2:       hexOf = 7'b0100100;
      3:       hexOf = 7'b0110000;
      4:       hexOf = 7'b0011001;
      5:       hexOf = 7'b0010010;
      6:       hexOf = 7'b0000010;
      7:       hexOf = 7'b1111000;
      8:       hexOf = 7'b0000000;
      9:       hexOf = 7'b0010000;
      default: hexOf = 7'b1111111;
    endcase
  endfunction

  // Model: reset clears everything and pretends the last win was long ago.
  task automatic modelReset();
    lScore     = 0;
    rScore     = 0;
    over       = 1'b0;
    lastWin    = -1000;
    acceptFrom = 0;
    code       = 2'b00;
  endtask

  // Model: one clock edge with the given inputs. A win at edge N shows its
  // winner through edge N+H-1, the clear pulse after edge N+H, and the next
  // win can be taken at edge N+H+2.
  task automatic modelStep(input bit lb, input bit rb, input bit le, input bit re);
    bit lw;
    bit rw;
    cyc++;
    if (!over && cyc >= acceptFrom) begin
      lw = le && lb && !rb && !re;
      rw = re && rb && !lb && !le;
      if (lw || rw) begin
        if (lw) begin
          lScore++;
          code = 2'b10;
          if (lScore == WIN) over = 1'b1;
        end else begin
          rScore++;
          code = 2'b01;
          if (rScore == WIN) over = 1'b1;
        end
        lastWin    = cyc;
        acceptFrom = cyc + HOLDC + 2;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string where);
    logic [1:0] expWinner;
    logic       expRr;
    if (over)
      expWinner = code;
    else if (cyc >= lastWin && cyc < lastWin + HOLDC)
      expWinner = code;
    else
      expWinner = 2'b00;
    expRr = !over && (cyc == lastWin + HOLDC);
    checkOutput({where, ".LeftScore"},   32'(bus.LeftScore),   32'(lScore));
    checkOutput({where, ".RightScore"},  32'(bus.RightScore),  32'(rScore));
    checkOutput({where, ".roundWinner"}, 32'(bus.roundWinner), 32'(expWinner));
    checkOutput({where, ".roundReset"},  32'(bus.roundReset),  32'(expRr));
    checkOutput({where, ".matchOver"},   32'(bus.matchOver),   32'(over));
    checkOutput({where, ".HEX5"},        32'(bus.HEX5),        32'(hexOf(lScore)));
    checkOutput({where, ".HEX0"},        32'(bus.HEX0),        32'(hexOf(rScore)));
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge act,
  // then sample 1 time unit later and compare with the model.
  task automatic applyStimulus(input string where, input bit rst, input bit lb, input bit rb,
                               input bit le, input bit re);
    @(negedge clock);
    reset             = rst;
    bus.LeftButton    = lb;
    bus.RightButton   = rb;
    bus.LeftEndLight  = le;
    bus.RightEndLight = re;
    @(posedge clock);
    #1;
    if (!rst) begin
      cyc++;
      modelReset();
    end else begin
      modelStep(lb, rb, le, re);
    end
    checkAll(where);
  endtask

  initial begin
    cyc               = 0;
    reset             = 1'b0;
    bus.LeftButton    = 1'b0;
    bus.RightButton   = 1'b0;
    bus.LeftEndLight  = 1'b0;
    bus.RightEndLight = 1'b0;
    modelReset();
    #2;
    checkAll("resetAsync");

    // Idle after reset: nothing should move.
    for (int i = 0; i < 5; i++) applyStimulus("idle", 1, 0, 0, 0, 0);

    // Left round win, then the hold window and clear pulse.
    applyStimulus("leftWin", 1, 1, 0, 1, 0);
    checkOutput("leftWin.directScore", 32'(bus.LeftScore), 32'd1);
    checkOutput("leftWin.directHex5", 32'(bus.HEX5), 32'(7'b1111001));
    for (int i = 0; i < HOLDC + 2; i++) applyStimulus("leftHold", 1, 0, 0, 0, 0);

    // Ambiguous and illegal chain states: no win.
    applyStimulus("bothButtons", 1, 1, 1, 1, 0);
    applyStimulus("bothLights", 1, 0, 1, 1, 1);
    applyStimulus("bothLightsL", 1, 1, 0, 1, 1);

    // Right win, then qualifying right presses through hold and clear cycle.
    applyStimulus("rightWin", 1, 0, 1, 0, 1);
    for (int i = 0; i < HOLDC + 1; i++) applyStimulus("rightDropped", 1, 0, 1, 0, 1);
    checkOutput("rightDropped.score", 32'(bus.RightScore), 32'd1);
    applyStimulus("rightAfter", 1, 0, 1, 0, 1);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", 1,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    // Fresh match: left win, reset pulled low between edges mid-hold.
    applyStimulus("preReset", 0, 0, 0, 0, 0);
    applyStimulus("midWin", 1, 1, 0, 1, 0);
    applyStimulus("midHold", 1, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll("asyncMidHold");
    applyStimulus("inReset", 0, 0, 0, 0, 0);
    for (int i = 0; i < HOLDC + 2; i++) applyStimulus("afterReset", 1, 0, 0, 0, 0);
    applyStimulus("winAfterReset", 1, 1, 0, 1, 0);
    checkOutput("winAfterReset.score", 32'(bus.LeftScore), 32'd1);

    // Fresh match: seven right wins separated by full rounds.
    applyStimulus("preMatch", 0, 0, 0, 0, 0);
    for (int w = 0; w < WIN; w++) begin
      applyStimulus("matchWin", 1, 0, 1, 0, 1);
      for (int i = 0; i < HOLDC + 1; i++) applyStimulus("matchGap", 1, 0, 0, 0, 0);
    end
    checkOutput("matchEnd.score", 32'(bus.RightScore), 32'(WIN));
    checkOutput("matchEnd.over", 32'(bus.matchOver), 32'd1);
    checkOutput("matchEnd.winner", 32'(bus.roundWinner), 32'(2'b01));
    checkOutput("matchEnd.hex0", 32'(bus.HEX0), 32'(7'b1111000));
    for (int i = 0; i < 6; i++) applyStimulus("overRight", 1, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus("overLeft", 1, 1, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tug_referee.md
# tug_referee

Round and match referee for the tug-of-war game. Reads the two end lights of the light chain together with the conditioned player press pulses, and decides when a round is won. It keeps each player's score and drives the two score digits. After each round win it pulses a clear to the light chain. It sits downstream of the light chain and upstream of the HEX displays.

## Interface

Parameters:
- WIN_SCORE, default 7: number of round wins that ends the match. Legal range 1..9.
- HOLD_CYCLES, default 4: number of cycles the round result is held before the chain is cleared. Must be ≥1.

Ports:
- clock, in, 1: single system clock. All logic is on posedge.
- reset, in, 1: asynchronous, active-low.
- LeftButton, in, 1: left player press. Already a one-cycle conditioned pulse.
- RightButton, in, 1: right player press. Already a one-cycle conditioned pulse.
- LeftEndLight, in, 1: state of the leftmost light in the chain.
- RightEndLight, in, 1: state of the rightmost light in the chain.
- roundReset, out, 1: one-cycle pulse that clears the light chain to centre.
- roundWinner, out, 2: round winner code. 2'b10 = left, 2'b01 = right, 2'b00 = none.
- matchOver, out, 1: high once either score reaches WIN_SCORE.
- LeftScore, out, 4: left player's round-win count.
- RightScore, out, 4: right player's round-win count.
- HEX5, out, 7: left score digit. Active-low segments, order {g,f,e,d,c,b,a}.
- HEX0, out, 7: right score digit. Same encoding as HEX5.

## Operation

State machine states: PLAY, HOLD, OVER. All outputs are registered.

Reset values (state forced while reset is low):
- state = PLAY.
- LeftScore = RightScore = 0.
- roundWinner = 2'b00, matchOver = 0, roundReset = 0.
- Hold counter = 0.
- HEX5 = HEX0 = 7'b1000000 (digit "0").

Win qualifiers, evaluated only in PLAY with roundReset = 0:
- leftWin = LeftEndLight & LeftButton & ~RightButton & ~RightEndLight.
- rightWin = RightEndLight & RightButton & ~LeftButton & ~LeftEndLight.
- Both end lights high is an illegal chain state: no win is declared.
- Both buttons pressed in the same cycle: no win is declared.

Transitions:
- PLAY → HOLD on leftWin or rightWin:
  - Increment the winner's score.
  - Set roundWinner to the winner's code.
  - Load the hold counter with HOLD_CYCLES-1.
- PLAY → OVER instead of HOLD when the incremented score equals WIN_SCORE:
  - Score and roundWinner update the same way.
  - matchOver = 1.
- HOLD: decrement the counter each cycle. On the edge where the counter is 0, go to PLAY with:
  - roundWinner = 2'b00.
  - roundReset = 1 for exactly that one PLAY cycle.
- OVER: terminal. All inputs are ignored. roundWinner and scores are held and roundReset is never asserted. Only reset leaves OVER.

Other rules:
- Scores never exceed WIN_SCORE, so no wrap-around is possible.
- HEX digits are a combinational decode of the registered scores:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value = 7'b1111111 (blank).
- Button pulses during HOLD, OVER, or the roundReset cycle are dropped, not queued.

## Timing

- Inputs are sampled at posedge N. A win updates the score, roundWinner and state so they are visible after edge N. Latency is 1 cycle.
- HOLD lasts exactly HOLD_CYCLES cycles.
- roundReset is high in the cycle after the last HOLD cycle. The next win can be recognised at the edge one cycle after roundReset deasserts.
- A round therefore occupies HOLD_CYCLES+1 cycles after the win before play resumes.
- Asserting reset asynchronously at any point, including mid-HOLD or in OVER, immediately forces all reset values. No roundReset pulse is emitted on reset.
- Release of reset is synchronous to clock: the first evaluation is at the next posedge.

## Test plan

1. Reset, then hold all inputs at 0 for 5 cycles → scores stay 0, HEX5 = HEX0 = 1000000, roundWinner = 00, roundReset = 0.
2. LeftEndLight = 1 with a one-cycle LeftButton pulse → next cycle LeftScore = 1, roundWinner = 10, HEX5 = 1111001. With default HOLD_CYCLES = 4: roundWinner holds 4 cycles, then roundReset = 1 for 1 cycle and roundWinner = 00.
3. Illegal and ambiguous cases: LeftEndLight = 1 with LeftButton and RightButton pressed together → no change. Both end lights = 1 with a RightButton pulse → no change.
4. A RightButton pulse with RightEndLight = 1 during HOLD, and again during the roundReset cycle → both ignored. RightScore is unchanged.
5. Seven right wins separated by full rounds → RightScore = 7, matchOver = 1, roundWinner = 01, HEX0 = 1111000, no roundReset. Further qualifying presses → no change.
6. Async reset pulled low mid-HOLD, between clock edges → outputs go to reset values immediately and no roundReset follows. A left win after release → LeftScore = 1.
